// File: rtl/mux8_scan_deserializer.sv
// Scans an external 8:1 mux through channels 0..7 and packs the samples into a byte
// behind a one-entry valid/ready buffer. Define MUX8_SCAN_PARITY_EN to add an even-parity output.
module mux8_scan_deserializer #(
  parameter int unsigned SETTLE = 0
) (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic       EN,
  output logic [2:0] S,
  input  logic       O,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY
`ifdef MUX8_SCAN_PARITY_EN
  ,
  output logic       PARITY
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FULL   = 2'd3
  } state_t;

  localparam bit         HAS_SETTLE  = (SETTLE != 32'd0);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 32'd1);

  function automatic logic even_parity(input logic [7:0] word);
    return ^word;
  endfunction

  state_t     state_r, state_nx_s, scan_state_s;
  logic [2:0] s_r, s_nx_s;
  logic [3:0] cnt_r, cnt_nx_s;
  logic [7:0] work_r, work_nx_s;
  logic [7:0] data_r, data_nx_s;
  logic       valid_r, valid_nx_s;
  logic       space_s, load_s;
  logic [7:0] load_word_s;

  // Next-state, scan position and output-buffer logic
  always_comb begin
    state_nx_s   = state_r;
    s_nx_s       = s_r;
    cnt_nx_s     = cnt_r;
    work_nx_s    = work_r;
    data_nx_s    = data_r;
    load_s       = 1'b0;
    load_word_s  = work_r;
    space_s      = !valid_r || READY;
    scan_state_s = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
    if (valid_r && READY) begin
      valid_nx_s = 1'b0;
    end else begin
      valid_nx_s = valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        s_nx_s   = 3'd0;
        cnt_nx_s = 4'd0;
        if (EN) begin
          state_nx_s = scan_state_s;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!EN) begin
          state_nx_s = ST_IDLE;
          s_nx_s     = 3'd0;
          cnt_nx_s   = 4'd0;
          work_nx_s  = 8'd0;
        end else if (cnt_r == SETTLE_LAST) begin
          state_nx_s = ST_SAMPLE;
          cnt_nx_s   = 4'd0;
        end else begin
          cnt_nx_s = cnt_r + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (!EN) begin
          state_nx_s = ST_IDLE;
          s_nx_s     = 3'd0;
          work_nx_s  = 8'd0;
        end else if (s_r != 3'd7) begin
          work_nx_s[s_r] = O;
          s_nx_s         = s_r + 3'd1;
          state_nx_s     = scan_state_s;
        end else if (space_s) begin
          load_s      = 1'b1;
          load_word_s = {O, work_r[6:0]};
        end else begin
          // Keep the last sample in the work register so nothing is re-taken.
          work_nx_s[7] = O;
          state_nx_s   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (space_s) begin
          load_s      = 1'b1;
          load_word_s = work_r;
        end else begin
          state_nx_s = ST_FULL;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        s_nx_s     = 3'd0;
        cnt_nx_s   = 4'd0;
        work_nx_s  = 8'd0;
      end
    endcase

    if (load_s) begin
      data_nx_s  = load_word_s;
      valid_nx_s = 1'b1;
      s_nx_s     = 3'd0;
      work_nx_s  = 8'd0;
      state_nx_s = EN ? scan_state_s : ST_IDLE;
    end else begin
      data_nx_s = data_r;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_r <= ST_IDLE;
      s_r     <= 3'd0;
      cnt_r   <= 4'd0;
      work_r  <= 8'd0;
      data_r  <= 8'd0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      s_r     <= s_nx_s;
      cnt_r   <= cnt_nx_s;
      work_r  <= work_nx_s;
      data_r  <= data_nx_s;
      valid_r <= valid_nx_s;
    end
  end

`ifdef MUX8_SCAN_PARITY_EN
  logic parity_r;

  // Parity register tracks DATA edge for edge
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= even_parity(data_nx_s);
    end
  end

  assign PARITY = parity_r;
`endif

  assign S     = s_r;
  assign DATA  = data_r;
  assign VALID = valid_r;

endmodule
